// File: rtl/seg_count_scheduler_if.sv
// Handshake and result bus between the segmentation front end (master) and
// seg_count_scheduler (slave). The seg_hi signal exists only when
// SEG_THRESH_EN is defined.
interface seg_count_scheduler_if #(
    parameter int NSEG = 6,
    parameter int CW   = 5
);
    logic [NSEG-1:0] seg_req;
    logic            frame_tick;
    logic [NSEG-1:0] seg_ack;
    logic            busy;
    logic [CW-1:0]   seg1countout;
    logic [CW-1:0]   seg2countout;
    logic [CW-1:0]   seg3countout;
    logic [CW-1:0]   seg4countout;
    logic [CW-1:0]   seg5countout;
    logic [CW-1:0]   seg6countout;
`ifdef SEG_THRESH_EN
    logic [NSEG-1:0] seg_hi;

    modport master (
        output seg_req, frame_tick,
        input  seg_ack, busy,
        input  seg1countout, seg2countout, seg3countout,
        input  seg4countout, seg5countout, seg6countout,
        input  seg_hi
    );

    modport slave (
        input  seg_req, frame_tick,
        output seg_ack, busy,
        output seg1countout, seg2countout, seg3countout,
        output seg4countout, seg5countout, seg6countout,
        output seg_hi
    );
`else
    modport master (
        output seg_req, frame_tick,
        input  seg_ack, busy,
        input  seg1countout, seg2countout, seg3countout,
        input  seg4countout, seg5countout, seg6countout
    );

    modport slave (
        input  seg_req, frame_tick,
        output seg_ack, busy,
        output seg1countout, seg2countout, seg3countout,
        output seg4countout, seg5countout, seg6countout
    );
`endif
endinterface

// File: rtl/seg_count_scheduler.sv
// seg_count_scheduler: round-robin arbitration of six segment-event requesters
// onto one saturating counter bank. Once per frame the bank is snapshotted to
// the segNcountout buses (inside vblank) and then cleared.
// Optional feature macro: SEG_THRESH_EN adds seg_hi (snapshot > THRESH).
module seg_count_scheduler #(
    parameter int NSEG   = 6,
    parameter int CW     = 5,
    parameter int MAXCNT = 31
`ifdef SEG_THRESH_EN
    ,
    parameter int THRESH = 6
`endif
) (
    input logic                  dclk,
    input logic                  clr_n,
    seg_count_scheduler_if.slave bus
);

    localparam int            PW    = $clog2(NSEG);
    localparam logic [CW-1:0] MAX_V = CW'(MAXCNT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SNAP  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   bank [NSEG];
    logic [CW-1:0]   snap [NSEG];
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;
    logic [NSEG-1:0] eligible;
    logic [NSEG-1:0] ack_q;
    logic [NSEG-1:0] ack_nxt;
    logic            grant_vld;
    logic            do_grant;

    // Round-robin search starting one past the last winner; an acked segment
    // is masked so a held request is not counted twice.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        eligible  = bus.seg_req & ~ack_q;
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int k = 1; k <= NSEG; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NSEG);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge dclk or negedge clr_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!clr_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Next state and grant decision; grants only in RUN and never on a frame_tick cycle.
    always_comb begin
        state_nxt = state;
        ack_nxt   = '0;
        do_grant  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (bus.frame_tick) begin
                    state_nxt = ST_SNAP;
                end else if (grant_vld) begin
                    do_grant = 1'b1;
                    ack_nxt  = NSEG'(1) << grant_idx;
                end
            end
            ST_SNAP:  state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Counter bank, grant register, round-robin pointer and snapshot registers.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: the bank and snapshot arrays are reset explicitly because an abandoned frame must not leak counts.
            for (int i = 0; i < NSEG; i++) begin
                bank[i] <= '0;
                snap[i] <= '0;
            end
            ack_q  <= '0;
            rr_ptr <= PW'(NSEG - 1);
        end else begin
            ack_q <= ack_nxt;
            if (do_grant) begin
                rr_ptr <= grant_idx;
                if (bank[grant_idx] != MAX_V)
                    bank[grant_idx] <= bank[grant_idx] + 1'b1;
            end
            if (state == ST_SNAP) begin
                for (int i = 0; i < NSEG; i++) snap[i] <= bank[i];
            end
            if (state == ST_CLEAR) begin
                for (int i = 0; i < NSEG; i++) bank[i] <= '0;
            end
        end
    end

`ifdef SEG_THRESH_EN
    logic [NSEG-1:0] hi_q;

    // Threshold flags captured on the same SNAP edge as the counts.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hi_q <= '0;
        end else if (state == ST_SNAP) begin
            for (int i = 0; i < NSEG; i++) hi_q[i] <= (bank[i] > CW'(THRESH));
        end
    end

    assign bus.seg_hi = hi_q;
`endif

    assign bus.seg_ack      = ack_q;
    assign bus.busy         = (state != ST_RUN);
    assign bus.seg1countout = snap[0];
    assign bus.seg2countout = snap[1];
    assign bus.seg3countout = snap[2];
    assign bus.seg4countout = snap[3];
    assign bus.seg5countout = snap[4];
    assign bus.seg6countout = snap[5];

endmodule
